mem_port_ctrl: RTL and testbench
================================

// Module: mem_port_ctrl
// PURPOSE
// Data-side memory responder for the load/store path. Accepts one LB..SW request from the issue/forward
// stage, runs it byte-serially on the 8-bit unified RAM bus, and returns a single-cycle mem_rdy plus
// sign-/zero-extended load data. It is the far end of the bubble handshake: upstream stalls from issue of a
// memory op until it samples mem_rdy high. Sits between the issue/forward stage and the RAM/IO pins.
// PARAMETERS
// IO_SEL   2'b11   mem addr[17:16] value selecting the IO region; stores there obey io_buffer_full
// PORTS
// clk             in   1   clock
// rst             in   1   synchronous active-high reset
// rdy             in   1   global enable; low freezes all state and outputs
// req_valid       in   1   request present (upstream issue_rdy of a memory op)
// req_name        in   6   op code: `LB `LH `LW `LBU `LHU `SB `SH `SW (const.v)
// req_addr        in   32  byte address (no alignment required)
// req_wdata       in   32  store data; low 1/2/4 bytes used
// mem_rdy         out  1   one-cycle pulse: request complete
// load_data       out  32  extended load result, valid while mem_rdy=1
// mem_din         in   8   RAM read byte
// mem_dout        out  8   RAM write byte
// mem_a           out  32  RAM byte address
// mem_wr          out  1   1=write, 0=read
// io_buffer_full  in   1   IO write buffer full
// BEHAVIOUR
// - Reset: state=IDLE; mem_rdy=0, load_data=0, mem_a=0, mem_dout=0, mem_wr=0; byte counter=0.
// - rdy=0: no register changes, incl. FSM, counters, mem_wr (held at current value).
// - Size N: B/BU=1, H/HU=2, W=4. Byte k address = req_addr+k (32-bit wrap); little-endian.
// - States: IDLE, LOAD, STORE. Request latched (name, addr, wdata) only in IDLE on req_valid=1.
// - Requests while not IDLE are ignored. Non-memory req_name values are ignored (stay IDLE).
// - Acceptance edge E0. RAM read latency is 1 cycle: byte placed on mem_a after edge Ek is on mem_din
//   after edge Ek+1 and is captured at edge Ek+2.
// - LOAD: at Ek (k<N) drive mem_a=addr+k, mem_wr=0; capture bytes at E2..EN+1. At EN+1: mem_rdy=1,
//   load_data=assembled value, state=IDLE, mem_a=0. Completion is N+1 cycles after E0.
// - Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend; LW passthrough.
// - STORE: at Ek drive mem_a=addr+k, mem_dout=wdata byte k, mem_wr=1. If the next byte's address is IO
//   (addr[17:16]==IO_SEL) and io_buffer_full=1, hold mem_wr=0 and do not advance k until it clears.
//   After the last byte is written: mem_wr=0, mem_a=0, mem_rdy=1, state=IDLE. Total N cycles without stalls.
// - mem_rdy is high for exactly one cycle per accepted request and low otherwise. load_data holds
//   between requests (0 after a store completes).
// - A new request is accepted on the edge where mem_rdy falls, i.e. back-to-back with a 1-cycle gap.
// - Reset mid-operation aborts: the next edge forces mem_wr=0 and no mem_rdy is produced.
// - Simultaneous rst and rdy=0: reset wins.
// TESTING
// - LW addr 0x100; RAM[0x100..0x103]=11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles; mem_rdy one
//   cycle at E5, load_data=0x44332211.
// - LB then LBU, addr 0x200, RAM=0x80 -> load_data=0xFFFFFF80, then 0x00000080; each completes at E2.
// - SH addr 0x3FF, wdata=0xABCD -> writes CD@0x3FF, AB@0x400, mem_wr=1 for 2 cycles; mem_rdy at E2.
// - SW to 0x30000 with io_buffer_full high for 3 cycles before byte 0 -> completion delayed by exactly 3
//   cycles; no mem_wr while full.
// - rst asserted at E2 of an LW -> mem_wr=0, mem_rdy never pulses, FSM IDLE; a following LB completes normally.
// - rdy low 2 cycles mid-LH -> outputs frozen; completion shifted by exactly 2 cycles, data unchanged.

Source files
------------

// File: rtl/mem_port_ctrl.sv
// Data-side memory responder: runs one LB..SW request byte-serially over the 8-bit RAM bus and
// returns a single-cycle mem_rdy with extended load data.
module mem_port_ctrl #(
  parameter logic [1:0] IO_SEL = 2'b11,
  parameter logic [5:0] OP_LB  = 6'd11,
  parameter logic [5:0] OP_LH  = 6'd12,
  parameter logic [5:0] OP_LW  = 6'd13,
  parameter logic [5:0] OP_LBU = 6'd14,
  parameter logic [5:0] OP_LHU = 6'd15,
  parameter logic [5:0] OP_SB  = 6'd16,
  parameter logic [5:0] OP_SH  = 6'd17,
  parameter logic [5:0] OP_SW  = 6'd18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        req_valid,
  input  logic [5:0]  req_name,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_rdy,
  output logic [31:0] load_data,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full
);

  typedef enum logic [1:0] {IDLE, LOAD, STORE} state_t;

  state_t      state_reg, state_next;
  logic [5:0]  name_reg, name_next;
  logic [31:0] addr_reg, addr_next;
  logic [31:0] wdata_reg, wdata_next;
  logic [2:0]  cnt_reg, cnt_next;
  logic [31:0] buf_reg, buf_next;
  logic        mem_rdy_reg, mem_rdy_next;
  logic [31:0] load_data_reg, load_data_next;
  logic [31:0] mem_a_reg, mem_a_next;
  logic [7:0]  mem_dout_reg, mem_dout_next;
  logic        mem_wr_reg, mem_wr_next;

  logic [7:0]  wbyte [4];
  logic [31:0] addr_k;
  logic [31:0] assembled;
  logic [1:0]  bidx;
  logic [2:0]  size_n;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_wbyte
      assign wbyte[gi] = wdata_reg[gi*8 +: 8];
    end
  endgenerate

  function automatic logic [2:0] op_size(input logic [5:0] name);
    logic [2:0] n;
    n = 3'd0;
    if (name == OP_LB || name == OP_LBU || name == OP_SB) n = 3'd1;
    else if (name == OP_LH || name == OP_LHU || name == OP_SH) n = 3'd2;
    else if (name == OP_LW || name == OP_SW) n = 3'd4;
    return n;
  endfunction

  function automatic logic is_load(input logic [5:0] name);
    return (name == OP_LB) || (name == OP_LH) || (name == OP_LW) ||
           (name == OP_LBU) || (name == OP_LHU);
  endfunction

  function automatic logic is_store(input logic [5:0] name);
    return (name == OP_SB) || (name == OP_SH) || (name == OP_SW);
  endfunction

  function automatic logic [31:0] extend(input logic [5:0] name, input logic [31:0] a);
    logic [31:0] r;
    r = a;
    if (name == OP_LB)       r = {{24{a[7]}}, a[7:0]};
    else if (name == OP_LH)  r = {{16{a[15]}}, a[15:0]};
    else if (name == OP_LBU) r = {24'd0, a[7:0]};
    else if (name == OP_LHU) r = {16'd0, a[15:0]};
    return r;
  endfunction

  // A store byte waits while its target lies in the IO region and the IO buffer is full.
  function automatic logic io_stall(input logic [31:0] a);
    return (a[17:16] == IO_SEL) && io_buffer_full;
  endfunction

  assign size_n = op_size(name_reg);
  assign addr_k = addr_reg + {29'd0, cnt_reg};
  assign bidx   = cnt_reg[1:0] - 2'd2;

  always_comb begin
    assembled = buf_reg;
    assembled[{bidx, 3'b000} +: 8] = mem_din;
  end

  always_comb begin
    state_next     = state_reg;
    name_next      = name_reg;
    addr_next      = addr_reg;
    wdata_next     = wdata_reg;
    cnt_next       = cnt_reg;
    buf_next       = buf_reg;
    mem_rdy_next   = 1'b0;
    load_data_next = load_data_reg;
    mem_a_next     = mem_a_reg;
    mem_dout_next  = mem_dout_reg;
    mem_wr_next    = mem_wr_reg;
    case (state_reg)
      IDLE: begin
        if (req_valid && is_load(req_name)) begin
          name_next   = req_name;
          addr_next   = req_addr;
          wdata_next  = req_wdata;
          buf_next    = 32'd0;
          state_next  = LOAD;
          mem_a_next  = req_addr;
          mem_wr_next = 1'b0;
          cnt_next    = 3'd1;
        end else if (req_valid && is_store(req_name)) begin
          name_next  = req_name;
          addr_next  = req_addr;
          wdata_next = req_wdata;
          state_next = STORE;
          if (io_stall(req_addr)) begin
            mem_wr_next = 1'b0;
            cnt_next    = 3'd0;
          end else begin
            mem_a_next    = req_addr;
            mem_dout_next = req_wdata[7:0];
            mem_wr_next   = 1'b1;
            cnt_next      = 3'd1;
          end
        end
      end
      LOAD: begin
        // cnt_reg is the index of the edge since acceptance; bytes land two edges after issue.
        if (cnt_reg >= 3'd2) buf_next = assembled;
        if (cnt_reg == size_n + 3'd1) begin
          mem_rdy_next   = 1'b1;
          load_data_next = extend(name_reg, assembled);
          mem_a_next     = 32'd0;
          state_next     = IDLE;
          cnt_next       = 3'd0;
        end else begin
          if (cnt_reg < size_n) mem_a_next = addr_k;
          cnt_next = cnt_reg + 3'd1;
        end
      end
      STORE: begin
        if (cnt_reg == size_n) begin
          mem_wr_next    = 1'b0;
          mem_a_next     = 32'd0;
          mem_rdy_next   = 1'b1;
          load_data_next = 32'd0;
          state_next     = IDLE;
          cnt_next       = 3'd0;
        end else if (io_stall(addr_k)) begin
          mem_wr_next = 1'b0;
        end else begin
          mem_a_next    = addr_k;
          mem_dout_next = wbyte[cnt_reg[1:0]];
          mem_wr_next   = 1'b1;
          cnt_next      = cnt_reg + 3'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      name_reg      <= 6'd0;
      addr_reg      <= 32'd0;
      wdata_reg     <= 32'd0;
      cnt_reg       <= 3'd0;
      buf_reg       <= 32'd0;
      mem_rdy_reg   <= 1'b0;
      load_data_reg <= 32'd0;
      mem_a_reg     <= 32'd0;
      mem_dout_reg  <= 8'd0;
      mem_wr_reg    <= 1'b0;
    end else if (rdy) begin
      state_reg     <= state_next;
      name_reg      <= name_next;
      addr_reg      <= addr_next;
      wdata_reg     <= wdata_next;
      cnt_reg       <= cnt_next;
      buf_reg       <= buf_next;
      mem_rdy_reg   <= mem_rdy_next;
      load_data_reg <= load_data_next;
      mem_a_reg     <= mem_a_next;
      mem_dout_reg  <= mem_dout_next;
      mem_wr_reg    <= mem_wr_next;
    end
  end

  assign mem_rdy   = mem_rdy_reg;
  assign load_data = load_data_reg;
  assign mem_a     = mem_a_reg;
  assign mem_dout  = mem_dout_reg;
  assign mem_wr    = mem_wr_reg;

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Bench for mem_port_ctrl: registered-read RAM model, write log and a completion scoreboard
// holding expected load data and completion edge for every accepted request.
module tb_mem_port_ctrl;

  localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14, LHU = 6'd15;
  localparam logic [5:0] SB = 6'd16, SH = 6'd17, SW = 6'd18;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rdy = 1'b1;
  logic        req_valid = 1'b0;
  logic [5:0]  req_name = 6'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        mem_rdy;
  logic [31:0] load_data;
  logic [7:0]  mem_din = 8'd0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full = 1'b0;

  mem_port_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .req_valid(req_valid), .req_name(req_name), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_rdy(mem_rdy), .load_data(load_data),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [7:0]  data;
  } wr_t;

  exp_t     exp_q[$];
  wr_t      wlog[$];
  bit [7:0] ram[bit [31:0]];
  int       cyc = 0;
  int       tests = 0;
  int       fails = 0;
  int       rdy_seen = 0;
  int       io_viol = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM with one-cycle registered read; writes are logged for later comparison.
  always @(posedge clk) begin
    if (mem_wr) begin
      ram[mem_a] = mem_dout;
      wlog.push_back('{addr: mem_a, data: mem_dout});
    end
    mem_din <= ram.exists(mem_a) ? ram[mem_a] : 8'h00;
  end

  // Completion monitor: each mem_rdy pops one scoreboard entry.
  always @(posedge clk) begin
    #1;
    if (mem_wr && io_buffer_full && mem_a[17:16] == 2'b11) io_viol++;
    if (mem_rdy) begin
      exp_t e;
      rdy_seen++;
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_mem_rdy: edge %0d load_data=%08h, required no completion", cyc, load_data);
      end else begin
        e = exp_q.pop_front();
        if (load_data !== e.data || cyc != e.cyc) begin
          fails++;
          $display("FAIL completion: edge %0d data %08h, required edge %0d data %08h",
                   cyc, load_data, e.cyc, e.data);
        end else begin
          $display("[TB] completion at edge %0d data %08h ok", cyc, load_data);
        end
      end
    end
  end

  // Called at a negedge; drives one request for one edge and returns at the following negedge.
  task automatic issue(input logic [5:0] name, input logic [31:0] addr, input logic [31:0] wdata,
                       input bit expect_done, input logic [31:0] data, input int lat);
    int e0;
    e0 = cyc + 1;
    req_valid = 1'b1;
    req_name  = name;
    req_addr  = addr;
    req_wdata = wdata;
    if (expect_done) exp_q.push_back('{data: data, cyc: e0 + lat});
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: %0d completions still pending after %0d cycles, required 0", exp_q.size(), max_cycles);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests += 5;
    if (mem_rdy !== 1'b0)    begin fails++; $display("FAIL reset_mem_rdy: got %b, required 0", mem_rdy); end
    if (load_data !== 32'd0) begin fails++; $display("FAIL reset_load_data: got %08h, required 0", load_data); end
    if (mem_a !== 32'd0)     begin fails++; $display("FAIL reset_mem_a: got %08h, required 0", mem_a); end
    if (mem_dout !== 8'd0)   begin fails++; $display("FAIL reset_mem_dout: got %02h, required 0", mem_dout); end
    if (mem_wr !== 1'b0)     begin fails++; $display("FAIL reset_mem_wr: got %b, required 0", mem_wr); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_lw();
    issue(LW, 32'h100, 32'd0, 1'b1, 32'h44332211, 5);
    for (int k = 0; k < 4; k++) begin
      tests++;
      if (mem_a !== 32'h100 + k || mem_wr !== 1'b0) begin
        fails++;
        $display("FAIL lw_addr%0d: mem_a=%08h mem_wr=%b, required %08h/0", k, mem_a, mem_wr, 32'h100 + k);
      end
      if (k < 3) @(negedge clk);
    end
    wait_done(20);
    tests++;
    if (mem_a !== 32'd0) begin fails++; $display("FAIL lw_mem_a_idle: got %08h, required 0", mem_a); end
  endtask

  task automatic test_lb_lbu();
    issue(LB, 32'h200, 32'd0, 1'b1, 32'hFFFFFF80, 2);
    wait_done(20);
    issue(LBU, 32'h200, 32'd0, 1'b1, 32'h00000080, 2);
    wait_done(20);
    tests++;
    if (load_data !== 32'h80) begin fails++; $display("FAIL lbu_hold: got %08h, required 00000080", load_data); end
  endtask

  task automatic test_sh();
    wlog.delete();
    issue(SH, 32'h3FF, 32'h0000ABCD, 1'b1, 32'd0, 2);
    wait_done(20);
    @(negedge clk);
    tests++;
    if (wlog.size() != 2 || wlog[0].addr !== 32'h3FF || wlog[0].data !== 8'hCD ||
        wlog[1].addr !== 32'h400 || wlog[1].data !== 8'hAB) begin
      fails++;
      $display("FAIL sh_writes: %0d writes, first %08h=%02h, required CD@3FF then AB@400",
               wlog.size(), wlog.size() > 0 ? wlog[0].addr : 32'd0, wlog.size() > 0 ? wlog[0].data : 8'd0);
    end
  endtask

  task automatic test_sw_io();
    wlog.delete();
    io_viol = 0;
    io_buffer_full = 1'b1;
    issue(SW, 32'h30000, 32'hDEADBEEF, 1'b1, 32'd0, 4 + 3);
    repeat (2) @(negedge clk);
    tests++;
    if (wlog.size() != 0 || mem_wr !== 1'b0) begin
      fails++;
      $display("FAIL sw_io_stall: %0d writes mem_wr=%b while full, required 0/0", wlog.size(), mem_wr);
    end
    io_buffer_full = 1'b0;
    wait_done(30);
    @(negedge clk);
    tests += 2;
    if (io_viol != 0) begin fails++; $display("FAIL sw_io_full_write: %0d writes while full, required 0", io_viol); end
    if (wlog.size() != 4 || wlog[0].data !== 8'hEF || wlog[3].addr !== 32'h30003 || wlog[3].data !== 8'hDE) begin
      fails++;
      $display("FAIL sw_io_writes: %0d writes, required EF,BE,AD,DE at 30000..30003", wlog.size());
    end
  endtask

  task automatic test_rst_abort();
    int seen0;
    seen0 = rdy_seen;
    issue(LW, 32'h100, 32'd0, 1'b0, 32'd0, 0);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_wr !== 1'b0 || mem_a !== 32'd0 || mem_rdy !== 1'b0) begin
      fails++;
      $display("FAIL rst_abort_outputs: mem_wr=%b mem_a=%08h mem_rdy=%b, required 0/0/0", mem_wr, mem_a, mem_rdy);
    end
    rst = 1'b0;
    repeat (8) @(negedge clk);
    tests++;
    if (rdy_seen != seen0) begin fails++; $display("FAIL rst_abort_rdy: %0d pulses, required 0", rdy_seen - seen0); end
    issue(LB, 32'h200, 32'd0, 1'b1, 32'hFFFFFF80, 2);
    wait_done(20);
  endtask

  task automatic test_rdy_freeze();
    logic [31:0] a0;
    issue(LH, 32'h210, 32'd0, 1'b1, 32'hFFFF9234, 3 + 2);
    a0 = mem_a;
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      tests++;
      if (mem_a !== a0 || mem_a !== 32'h210 || mem_rdy !== 1'b0) begin
        fails++;
        $display("FAIL rdy_freeze%0d: mem_a=%08h mem_rdy=%b, required 00000210/0", i, mem_a, mem_rdy);
      end
    end
    rdy = 1'b1;
    wait_done(20);
  endtask

  task automatic test_back_to_back();
    int seen0;
    wlog.delete();
    seen0 = rdy_seen;
    issue(LW, 32'h100, 32'd0, 1'b1, 32'h44332211, 5);
    req_valid = 1'b1;
    req_name  = SB;
    req_addr  = 32'h500;
    req_wdata = 32'h5A;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_done(20);
    issue(LHU, 32'h210, 32'd0, 1'b1, 32'h00009234, 3);
    wait_done(20);
    issue(6'd0, 32'h100, 32'd0, 1'b0, 32'd0, 0);
    repeat (6) @(negedge clk);
    tests += 2;
    if (wlog.size() != 0) begin fails++; $display("FAIL b2b_busy_ignored: %0d writes, required 0", wlog.size()); end
    if (rdy_seen - seen0 != 2) begin
      fails++;
      $display("FAIL b2b_pulses: %0d mem_rdy pulses, required 2", rdy_seen - seen0);
    end
  endtask

  initial begin
    ram[32'h100] = 8'h11; ram[32'h101] = 8'h22; ram[32'h102] = 8'h33; ram[32'h103] = 8'h44;
    ram[32'h200] = 8'h80;
    ram[32'h210] = 8'h34; ram[32'h211] = 8'h92;
    @(negedge clk);
    test_reset();
    test_lw();
    test_lb_lbu();
    test_sh();
    test_sw_io();
    test_rst_abort();
    test_rdy_freeze();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
